// File: rtl/seq_pkg.sv
// Shared types and defaults for the stack program sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    NA_RESET,
    NA_RET,
    NA_CALL,
    NA_JMP,
    NA_JNZ,
    NA_IRQ,
    NA_INC
  } next_src_e;

  localparam int DEF_PC_W        = 8;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_RESET_VEC   = 0;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_return_stack.sv
// Parametrised LIFO holding return addresses; push is ignored when full, pop when empty.
module seq_return_stack
  import seq_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH,
  parameter int WIDTH = DEF_PC_W,
  localparam int SP_W = sp_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_d;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign top    = mem_q[rd_idx];
  assign sp     = sp_q;

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end else if (push && !full) begin
      mem_d[wr_idx] = din;
      sp_d          = sp_q + SP_W'(1);
    end
  end

  // Entries above sp are don't-care, so only the pointer is reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/stack_program_sequencer.sv
// Program sequencer with call/return stack; interrupt entry is built only when SEQ_IRQ_EN is defined.
module stack_program_sequencer
  import seq_pkg::*;
#(
  parameter int          PC_W        = DEF_PC_W,
  parameter int          STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned RESET_VEC   = DEF_RESET_VEC,
`ifdef SEQ_IRQ_EN
  parameter int unsigned INT_VEC     = (1 << PC_W) - 16,
`endif
  localparam int SP_W = sp_width(STACK_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            jmp,
  input  logic            jmp_nz,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jmp_addr,
  input  logic            dont_jmp,
`ifdef SEQ_IRQ_EN
  input  logic            irq,
  input  logic            ei,
  input  logic            di,
  input  logic            reti,
  output logic            irq_ack,
`endif
  output logic [PC_W-1:0] pm_addr,
  output logic [PC_W-1:0] pc,
  output logic [SP_W-1:0] sp,
  output logic            stack_ovf,
  output logic            stack_unf
);

  next_src_e       src;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ret_any;
  logic            irq_take;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

`ifdef SEQ_IRQ_EN
  logic int_en_q, int_en_d;
  logic irq_ack_q, irq_ack_d;

  assign ret_any  = ret | reti;
  assign irq_take = irq & int_en_q & ~stk_full;
`else
  assign ret_any  = ret;
  assign irq_take = 1'b0;
`endif

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    if (!reset_n)                src = NA_RESET;
    else if (ret_any)            src = NA_RET;
    else if (call)               src = NA_CALL;
    else if (jmp)                src = NA_JMP;
    else if (jmp_nz && !dont_jmp) src = NA_JNZ;
    else if (irq_take)           src = NA_IRQ;
    else                         src = NA_INC;
  end

  // An underflowing return falls through to the next sequential address.
  always_comb begin
    case (src)
      NA_RESET: pm_addr = PC_W'(RESET_VEC);
      NA_RET:   pm_addr = stk_empty ? pc_inc : stk_top;
      NA_CALL,
      NA_JMP,
      NA_JNZ:   pm_addr = jmp_addr;
`ifdef SEQ_IRQ_EN
      NA_IRQ:   pm_addr = PC_W'(INT_VEC);
`endif
      default:  pm_addr = pc_inc;
    endcase
  end

  assign stk_push = (src == NA_CALL) || (src == NA_IRQ);
  assign stk_pop  = (src == NA_RET);

  seq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (pc_inc),
    .top     (stk_top),
    .sp      (sp),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_comb begin
    pc_d  = pm_addr;
    ovf_d = ovf_q | ((src == NA_CALL) & stk_full);
    unf_d = unf_q | ((src == NA_RET) & stk_empty);
  end

`ifdef SEQ_IRQ_EN
  // Entry clears int_en last so it dominates an ei in the same cycle.
  always_comb begin
    int_en_d = int_en_q;
    if ((src == NA_RET) && reti) int_en_d = 1'b1;
    if (ei)                      int_en_d = 1'b1;
    if (di)                      int_en_d = 1'b0;
    if (src == NA_IRQ)           int_en_d = 1'b0;
    irq_ack_d = (src == NA_IRQ);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_en_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      int_en_q  <= int_en_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign irq_ack = irq_ack_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= PC_W'(RESET_VEC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Randomized and directed bench for stack_program_sequencer against a queue-based reference model.
module tb_stack_program_sequencer;

  localparam int PC_W    = 8;
  localparam int DEPTH   = 4;
  localparam int RST_VEC = 0;
  localparam int IRQ_VEC = 8'hF0;

  logic       clk;
  logic       reset_n;
  logic       jmp, jmp_nz, call, ret, dont_jmp;
  logic [7:0] jmp_addr;
  logic       irq, ei, di, reti;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_ovf, stack_unf;
  logic       irq_ack;

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf, m_int_en, m_ack;

  stack_program_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
`ifdef SEQ_IRQ_EN
    .INT_VEC     (IRQ_VEC),
`endif
    .RESET_VEC   (RST_VEC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .call      (call),
    .ret       (ret),
    .jmp_addr  (jmp_addr),
    .dont_jmp  (dont_jmp),
`ifdef SEQ_IRQ_EN
    .irq       (irq),
    .ei        (ei),
    .di        (di),
    .reti      (reti),
    .irq_ack   (irq_ack),
`endif
    .pm_addr   (pm_addr),
    .pc        (pc),
    .sp        (sp),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

`ifndef SEQ_IRQ_EN
  assign irq_ack = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, predicts the outcome from the sequencer's rules and checks the DUT.
  task automatic applyStimulus(input bit rn, input bit j, input bit jn, input bit c,
                               input bit r, input int a, input bit dz,
                               input bit iq, input bit e, input bit d, input bit ri);
    int  inc, nxt;
    bit  enter;
`ifndef SEQ_IRQ_EN
    iq = 0; e = 0; d = 0; ri = 0;
`endif
    reset_n = rn; jmp = j; jmp_nz = jn; call = c; ret = r;
    jmp_addr = a[7:0]; dont_jmp = dz; irq = iq; ei = e; di = d; reti = ri;

    inc   = (m_pc + 1) % 256;
    enter = 0;
    if (!rn)                                          nxt = RST_VEC;
    else if (r || ri)                                 nxt = (m_stack.size() > 0) ? m_stack[$] : inc;
    else if (c || j || (jn && !dz))                   nxt = a % 256;
    else if (iq && m_int_en && m_stack.size() < DEPTH) begin nxt = IRQ_VEC; enter = 1; end
    else                                              nxt = inc;

    @(negedge clk);
    checkOutput("pm_addr", pm_addr, nxt);
    @(posedge clk);

    if (!rn) begin
      m_stack.delete();
      m_ovf = 0; m_unf = 0; m_int_en = 0; m_ack = 0;
    end else begin
      if (r || ri) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else m_unf = 1;
        if (ri) m_int_en = 1;
      end else if (c) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(inc);
        else m_ovf = 1;
      end else if (enter) begin
        m_stack.push_back(inc);
      end
      if (e) m_int_en = 1;
      if (d) m_int_en = 0;
      if (enter) m_int_en = 0;
      m_ack = enter;
    end
    m_pc = nxt;

    #1;
    checkOutput("pc", pc, m_pc);
    checkOutput("sp", sp, m_stack.size());
    checkOutput("stack_ovf", stack_ovf, m_ovf);
    checkOutput("stack_unf", stack_unf, m_unf);
`ifdef SEQ_IRQ_EN
    checkOutput("irq_ack", irq_ack, m_ack);
`endif
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doJmp(input int a);
    applyStimulus(1, 1, 0, 0, 0, a, 0, 0, 0, 0, 0);
  endtask

  task automatic doCall(input int a);
    applyStimulus(1, 0, 0, 1, 0, a, 0, 0, 0, 0, 0);
  endtask

  task automatic doRet();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 0; jmp = 0; jmp_nz = 0; call = 0; ret = 0;
    jmp_addr = '0; dont_jmp = 0; irq = 0; ei = 0; di = 0; reti = 0;
    m_pc = 0;

    // Reset, sequential fetch and wrap
    doReset();
    checkOutput("reset_pc", pc, 8'h00);
    idle(); idle(); idle();
    checkOutput("seq_pc", pc, 8'h03);
    doJmp(8'hFF);
    idle();
    checkOutput("wrap_pc", pc, 8'h00);

    // Conditional jump both ways, then jmp+call together
    doJmp(8'h05);
    applyStimulus(1, 0, 1, 0, 0, 8'h40, 1, 0, 0, 0, 0);
    checkOutput("jnz_not_taken", pc, 8'h06);
    doJmp(8'h05);
    applyStimulus(1, 0, 1, 0, 0, 8'h40, 0, 0, 0, 0, 0);
    checkOutput("jnz_taken", pc, 8'h40);
    doJmp(8'h05);
    applyStimulus(1, 1, 0, 1, 0, 8'h40, 0, 0, 0, 0, 0);
    checkOutput("jmp_call_sp", sp, 1);
    doRet();
    checkOutput("jmp_call_ret", pc, 8'h06);

    // Nested calls
    doJmp(8'h10);
    doCall(8'h20);
    idle();
    doCall(8'h30);
    checkOutput("nest_sp2", sp, 2);
    doRet();
    checkOutput("nest_ret1", pc, 8'h22);
    doRet();
    checkOutput("nest_ret2", pc, 8'h11);

    // Overflow and underflow
    for (int i = 0; i < 5; i++) doCall(8'h80 + i);
    checkOutput("ovf_target", pc, 8'h84);
    checkOutput("ovf_flag", stack_ovf, 1);
    for (int i = 0; i < 5; i++) doRet();
    checkOutput("unf_flag", stack_unf, 1);

`ifdef SEQ_IRQ_EN
    // Interrupt entry, no re-entry while disabled, reti
    doReset();
    doJmp(8'h06);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("irq_entry_pc", pc, 8'hF0);
    checkOutput("irq_ack_hi", irq_ack, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("irq_masked_pc", pc, 8'hF1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("reti_pc", pc, 8'h08);

    // Entry deferred while the stack is full
    for (int i = 0; i < 4; i++) doCall(8'h50 + i);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("deferred_entry", pc, 8'hF0);

    // Reset while the ISR runs with sp=3
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    doCall(8'h20);
    doCall(8'h30);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("isr_sp3", sp, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("midreset_pc", pc, 8'h00);
    checkOutput("midreset_ack", irq_ack, 0);
`endif

    // Randomized traffic
    doReset();
    for (int n = 0; n < 600; n++) begin
      int sel;
      bit rn, j, jn, c, r, dz, iq, e, d, ri;
      rn = ($urandom_range(0, 99) >= 2);
      j = 0; jn = 0; c = 0; r = 0; e = 0; d = 0; ri = 0;
      sel = $urandom_range(0, 11);
      case (sel)
        0: j  = 1;
        1: jn = 1;
        2, 3: c = 1;
        4: r  = 1;
        5: ri = 1;
        6, 7: e = 1;
        8: d  = 1;
        default: ;
      endcase
      if ($urandom_range(0, 19) == 0) begin
        j = $urandom_range(0, 1); c = $urandom_range(0, 1);
        r = $urandom_range(0, 1); jn = $urandom_range(0, 1);
        e = $urandom_range(0, 1); d = $urandom_range(0, 1);
      end
      dz = $urandom_range(0, 1);
      iq = ($urandom_range(0, 9) < 3);
      applyStimulus(rn, j, jn, c, r, $urandom_range(0, 255), dz, iq, e, d, ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_program_sequencer.md
# stack_program_sequencer

Parametrised successor to the micro's program sequencer. Generates the program-memory address each cycle and adds features the existing sequencer lacks: full-width jump targets, a hardware call/return stack, and optional single-level interrupt entry. It sits between the instruction decoder (flow-control strobes) and the program memory (clocked on ~clk). The computational unit supplies the zero flag.

## Interface
Parameters:
- PC_W, 8, program address width; pc and pm_addr wrap modulo 2^PC_W.
- STACK_DEPTH, 4, return-stack entries; must be ≥1.
- RESET_VEC, 0, address fetched out of reset.
- INT_VEC, 2^PC_W-16, interrupt entry address (macro-gated).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- jmp  in  1  unconditional jump strobe.
- jmp_nz  in  1  conditional jump; taken when dont_jmp=0.
- call  in  1  push pc+1, jump to jmp_addr.
- ret  in  1  pop stack into next address.
- jmp_addr  in  PC_W  target for jmp/jmp_nz/call.
- dont_jmp  in  1  zero flag from computational unit.
- irq, ei, di, reti  in  1 each  interrupt request (level), enable, disable, return-from-interrupt. Present only with the macro.
- pm_addr  out  PC_W  combinational next fetch address.
- pc  out  PC_W  registered current address.
- sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- stack_ovf, stack_unf  out  1  sticky error flags.
- irq_ack  out  1  one-cycle interrupt acknowledge (macro-gated).

## Operation
- pm_addr source priority:
  - reset_n=0 → RESET_VEC.
  - ret/reti → stack top.
  - call → jmp_addr.
  - jmp → jmp_addr.
  - jmp_nz & !dont_jmp → jmp_addr.
  - interrupt entry → INT_VEC.
  - else pc+1.
- The decoder drives strobes one-hot. If several are asserted, the priority above resolves them silently.
- pc <= pm_addr on every posedge.
- call:
  - Push pc+1 (wrapped) and increment sp.
  - When sp==STACK_DEPTH, the push is discarded, stack_ovf is set, and the jump still occurs.
- ret:
  - Pop the top entry and decrement sp.
  - When sp==0, pm_addr=pc+1, sp stays 0, and stack_unf is set.
- Stack is LIFO; entries above sp are don't-care.
- Interrupt entry occurs when all of the following hold:
  - irq & int_en.
  - No ret/call/jmp or taken jmp_nz in the same cycle.
  - sp<STACK_DEPTH. If the stack is full, entry is deferred without raising stack_ovf.
- On entry:
  - Push pc+1.
  - pm_addr=INT_VEC.
  - Clear int_en.
- int_en control:
  - ei sets int_en; di clears it; di wins if both are asserted.
  - reti behaves as ret and also sets int_en.
  - A reti underflow still sets int_en.
- Flags clear only on reset.

## Timing
- pm_addr: zero-cycle combinational path from strobes, dont_jmp, pc, and stack top. Memory samples it on the next negedge.
- The instruction fetched from pm_addr reaches ir one posedge later. Jump/call/ret therefore have a one-instruction latency; there is no delay slot because the next address is resolved in the same cycle.
- Reset (sampled at posedge with reset_n=0) sets: pc=RESET_VEC, sp=0, stack_ovf=0, stack_unf=0, int_en=0, irq_ack=0. pm_addr=RESET_VEC for as long as reset_n=0.
- Reset mid-call or mid-interrupt: pending push/pop is dropped and the stack is emptied.
- irq_ack is registered. It is high for exactly the one cycle in which pc==INT_VEC after an entry.
- pc+1 at 2^PC_W-1 wraps to 0, including a pushed return address.

## Configuration
- SEQ_IRQ_EN defined:
  - Ports irq, ei, di, reti, irq_ack exist.
  - int_en register and entry logic are present.
- SEQ_IRQ_EN undefined:
  - Those ports and the int_en logic are absent.
  - Sequencer is call/ret/jump only.
  - INT_VEC is unused.

## Structure
- Package seq_pkg contains:
  - The next-address source enum: NA_RESET, NA_RET, NA_CALL, NA_JMP, NA_JNZ, NA_IRQ, NA_INC.
  - Default parameter constants.
  - The sp-width function.
- Sub-module seq_return_stack: parametrised LIFO.
  - Inputs: push, pop, din.
  - Outputs: top, sp, full, empty.
  - Sticky ovf/unf flags are kept in the sequencer.

## Test plan
Bench uses PC_W=8, STACK_DEPTH=4, RESET_VEC=0, INT_VEC=F0, macro defined.
- Reset and wrap: hold reset_n=0 for 2 cycles, release, idle → pm_addr 00,01,02…; from pc=FF, next pc=00.
- Jumps: jmp_nz with jmp_addr=40 at pc=05:
  - dont_jmp=1 → pc=06.
  - dont_jmp=0 → pc=40.
  - jmp and call asserted together → call wins; return address 06 is pushed.
- Nested calls: call at pc=10→20, call at pc=21→30, ret→22, ret→11; sp goes 1,2,1,0.
- Overflow/underflow:
  - 5 calls → sp=4, stack_ovf=1, 5th target still taken.
  - 5 rets → 4 correct returns, then pc+1, stack_unf=1.
- Interrupt: ei, irq=1 at pc=07 (no strobe) → pc=F0, irq_ack=1 for one cycle, int_en=0. Then reti → pc=08, int_en=1. irq with sp=4 → no entry until a ret frees a slot.
- Reset mid-operation: reset_n=0 while sp=3 and the ISR is active → pc=00, sp=0, flags 0, irq_ack=0.
